// File: rtl/sccb_pkg.sv
// Shared SCCB responder types and constants.
// The optional read path is enabled by defining SCCB_READ_EN.
package sccb_pkg;
  localparam logic       SCCB_ACK    = 1'b0;
  localparam logic       SCCB_NACK   = 1'b1;
  localparam logic [7:0] SCCB_DEF_ID = 8'h42;

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = 4'd8;

  typedef logic [3:0] sccb_state_t;
  localparam sccb_state_t ST_IDLE      = 4'd0;
  localparam sccb_state_t ST_ID        = 4'd1;
  localparam sccb_state_t ST_ID_ACK    = 4'd2;
  localparam sccb_state_t ST_SUB       = 4'd3;
  localparam sccb_state_t ST_SUB_ACK   = 4'd4;
  localparam sccb_state_t ST_WDATA     = 4'd5;
  localparam sccb_state_t ST_WDATA_ACK = 4'd6;
  localparam sccb_state_t ST_RDATA     = 4'd7;
  localparam sccb_state_t ST_RDATA_ACK = 4'd8;
  localparam sccb_state_t ST_IGNORE    = 4'd9;
endpackage

// File: rtl/sccb_responder_if.sv
// SCCB pad and host register-port bundle.
// slave = responder side, master = bus/host side.
interface sccb_responder_if;
  import sccb_pkg::*;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, rd_addr,
    output sda_oe, wr_valid, wr_addr,
    output wr_data, rd_data, busy
  );
  modport master (
    output scl_i, sda_i, rd_addr,
    input  sda_oe, wr_valid, wr_addr,
    input  wr_data, rd_data, busy
  );
endinterface

// File: rtl/sccb_line_filter.sv
// Pad synchronizer, majority-free run-length glitch filter and
// edge pulses; a level change needs FILT_LEN identical samples.
module sccb_line_filter
  import sccb_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam logic [3:0] LIM = 4'(FILT_LEN - 1);

  logic       s0;
  logic       s1;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    s0 <= din;
    s1 <= s0;
  end

  // In reset the level tracks the pad so release makes no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= s1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s1 == level) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        level <= s1;
        cnt   <= '0;
        rise  <= s1;
        fall  <= ~s1;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/sccb_responder.sv
// SCCB/I2C target with a 256x8 register file and host read port.
// Define SCCB_READ_EN to build the read ID and RDATA path.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID   = SCCB_DEF_ID,
  parameter int         FILT_LEN = 3
) (
  input  logic              CLK,
  input  logic              RST,
  sccb_responder_if.slave   bus
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(CLK), .rst(RST), .din(bus.scl_i),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(CLK), .rst(RST), .din(bus.sda_i),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  // Coincident SCL/SDA edges are data, never START/STOP.
  logic scl_edge, start, stop;
  assign scl_edge = scl_rise | scl_fall;
  assign start = sda_fall & scl_lvl & ~scl_edge;
  assign stop  = sda_rise & scl_lvl & ~scl_edge;

  sccb_state_t          state;
  logic [BIT_CNT_W-1:0] bitcnt;
  logic [7:0]           shreg;
  logic [7:0]           ptr;
  logic                 sda_oe_q;
  logic                 busy_q;
  logic                 wr_valid_q;
  logic [7:0]           wr_addr_q;
  logic [7:0]           wr_data_q;
  logic [7:0]           rd_data_q;
`ifdef SCCB_READ_EN
  logic                 rd_mode;
  logic                 mack;
  logic [7:0]           rf_rd;
`endif

  logic [7:0] regfile [256];
  logic       sweeping;
  logic [7:0] clr_cnt;
  logic [7:0] byte_in;
  logic       commit;
  logic       rf_we;
  logic [7:0] rf_wa;
  logic [7:0] rf_wd;

  assign byte_in = {shreg[6:0], sda_lvl};
  assign commit  = ~RST & ~sweeping & scl_rise
                 & (state == ST_WDATA) & (bitcnt == 4'd7);
  assign rf_we   = sweeping | commit;
  assign rf_wa   = sweeping ? clr_cnt : ptr;
  assign rf_wd   = sweeping ? 8'h00 : byte_in;
`ifdef SCCB_READ_EN
  assign rf_rd   = regfile[ptr];
`endif

  always_ff @(posedge CLK) begin
    if (rf_we) regfile[rf_wa] <= rf_wd;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sweeping <= 1'b1;
      clr_cnt  <= '0;
    end else if (sweeping) begin
      clr_cnt <= clr_cnt + 8'd1;
      if (clr_cnt == 8'hFF) sweeping <= 1'b0;
    end
  end

  // Write-first host read; zero while the clear sweep runs.
  always_ff @(posedge CLK) begin
    if (RST || sweeping)
      rd_data_q <= '0;
    else if (commit && bus.rd_addr == ptr)
      rd_data_q <= byte_in;
    else
      rd_data_q <= regfile[bus.rd_addr];
  end

  always_ff @(posedge CLK) begin
    wr_valid_q <= 1'b0;
    if (RST) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      ptr       <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef SCCB_READ_EN
      rd_mode   <= 1'b0;
      mack      <= SCCB_NACK;
`endif
    end else if (start) begin
      state    <= ST_ID;
      bitcnt   <= '0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b1;
    end else if (stop) begin
      state    <= ST_IDLE;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        ST_ID, ST_SUB, ST_WDATA: begin
          if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 4'd1;
          end
          if (commit) begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= ptr;
            wr_data_q  <= byte_in;
            ptr        <= ptr + 8'd1;
          end
          if (scl_fall && bitcnt == BYTE_BITS) begin
            bitcnt   <= '0;
            sda_oe_q <= ~SCCB_ACK;
            if (state == ST_SUB) begin
              ptr   <= shreg;
              state <= ST_SUB_ACK;
            end else if (state == ST_WDATA) begin
              state <= ST_WDATA_ACK;
            end else if (shreg == DEV_ID) begin
              state <= ST_ID_ACK;
`ifdef SCCB_READ_EN
              rd_mode <= 1'b0;
            end else if (shreg == (DEV_ID | 8'h01)) begin
              state   <= ST_ID_ACK;
              rd_mode <= 1'b1;
`endif
            end else begin
              state    <= ST_IGNORE;
              sda_oe_q <= ~SCCB_NACK;
            end
          end
        end
        ST_ID_ACK: begin
          if (scl_fall) begin
            bitcnt   <= '0;
            sda_oe_q <= 1'b0;
`ifdef SCCB_READ_EN
            if (rd_mode) begin
              state    <= ST_RDATA;
              shreg    <= rf_rd;
              sda_oe_q <= ~rf_rd[7];
            end else begin
              state <= ST_SUB;
            end
`else
            state <= ST_SUB;
`endif
          end
        end
        ST_SUB_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            bitcnt   <= '0;
            sda_oe_q <= 1'b0;
            state    <= ST_WDATA;
          end
        end
`ifdef SCCB_READ_EN
        ST_RDATA: begin
          if (scl_rise) bitcnt <= bitcnt + 4'd1;
          if (scl_fall) begin
            if (bitcnt == BYTE_BITS) begin
              bitcnt   <= '0;
              sda_oe_q <= 1'b0;
              ptr      <= ptr + 8'd1;
              state    <= ST_RDATA_ACK;
            end else begin
              sda_oe_q <= ~shreg[6];
              shreg    <= {shreg[6:0], 1'b0};
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) mack <= sda_lvl;
          if (scl_fall) begin
            if (mack == SCCB_ACK) begin
              state    <= ST_RDATA;
              bitcnt   <= '0;
              shreg    <= rf_rd;
              sda_oe_q <= ~rf_rd[7];
            end else begin
              state <= ST_IGNORE;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Reset releases the pad in the very cycle it is sampled.
  assign bus.sda_oe   = sda_oe_q & ~RST;
  assign bus.busy     = busy_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_sccb_responder.sv
// Scoreboard bench for sccb_responder: bus master tasks queue
// expected ACK/read bits, commits and host reads; monitors compare.
`timescale 1ns/1ps
module tb_sccb_responder;
  import sccb_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic glitch = 1'b0;
  logic chk_slot = 1'b0;
  logic rd_req = 1'b0;
  logic [7:0] rd_addr = 8'h00;

  int errs = 0;
  int checks = 0;
  int oe_cycles = 0;
  int oe0;

  logic [15:0] wr_q[$];
  logic        bit_q[$];
  logic [7:0]  rd_q[$];

  sccb_responder_if bif();
  assign bif.scl_i   = m_scl;
  assign bif.sda_i   = m_sda & ~bif.sda_oe;
  assign bif.rd_addr = rd_addr;

  sccb_responder #(.DEV_ID(8'h42), .FILT_LEN(3)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bif.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%02h want=%02h", name, act, exp);
    end
  endtask

  // Commit and host-read monitor.
  initial forever begin
    @(negedge CLK);
    if (bif.sda_oe) oe_cycles++;
    if (bif.wr_valid) begin
      checks++;
      if (wr_q.size() == 0) begin
        errs++;
        $display("FAIL wr_unexpected got=%02h:%02h want=none",
                 bif.wr_addr, bif.wr_data);
      end else begin
        logic [15:0] e;
        e = wr_q.pop_front();
        if ({bif.wr_addr, bif.wr_data} !== e) begin
          errs++;
          $display("FAIL wr_commit got=%02h:%02h want=%02h:%02h",
                   bif.wr_addr, bif.wr_data, e[15:8], e[7:0]);
        end
      end
    end
    if (rd_req) begin
      checks++;
      if (rd_q.size() == 0) begin
        errs++;
        $display("FAIL rd_noexp got=%02h want=none", bif.rd_data);
      end else begin
        logic [7:0] e;
        e = rd_q.pop_front();
        if (bif.rd_data !== e) begin
          errs++;
          $display("FAIL rd_data[%02h] got=%02h want=%02h",
                   rd_addr, bif.rd_data, e);
        end
      end
    end
  end

  // Bus-bit monitor: line level at each checked SCL rise.
  initial forever begin
    @(posedge m_scl);
    if (chk_slot) begin
      checks++;
      if (bit_q.size() == 0) begin
        errs++;
        $display("FAIL bus_bit_noexp got=%0b want=none", bif.sda_i);
      end else begin
        logic e;
        e = bit_q.pop_front();
        if (bif.sda_i !== e) begin
          errs++;
          $display("FAIL bus_bit got=%0b want=%0b", bif.sda_i, e);
        end
      end
    end
  end

  task automatic qtr();
    repeat (16) @(posedge CLK);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; qtr();
    m_scl = 1'b1; qtr();
    m_sda = 1'b0; qtr();
    m_scl = 1'b0; qtr();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; qtr();
    m_scl = 1'b1; qtr();
    m_sda = 1'b1; qtr();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; qtr();
    m_scl = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    if (glitch) m_sda = ~b;
    @(posedge CLK);
    #1 m_sda = b;
    repeat (23) @(posedge CLK);
    #1 m_scl = 1'b0; qtr();
  endtask

  task automatic slot();
    m_sda = 1'b1; qtr();
    chk_slot = 1'b1;
    m_scl = 1'b1; qtr();
    chk_slot = 1'b0; qtr();
    m_scl = 1'b0; qtr();
  endtask

  // line: expected SDA level in the ACK slot (0 = ACK).
  task automatic write_byte(input logic [7:0] b, input logic line);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    bit_q.push_back(line);
    slot();
  endtask

  task automatic read_byte(input logic [7:0] e, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      bit_q.push_back(e[i]);
      slot();
    end
    send_bit(mack);
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] e);
    @(posedge CLK);
    #1 rd_addr = a;
    rd_q.push_back(e);
    @(posedge CLK);
    #1 rd_req = 1'b1;
    @(negedge CLK);
    #1 rd_req = 1'b0;
  endtask

  initial begin
    repeat (10) @(posedge CLK);
    #1;
    check("rst_busy", {7'd0, bif.busy}, 8'h00);
    check("rst_sda_oe", {7'd0, bif.sda_oe}, 8'h00);
    check("rst_rd_data", bif.rd_data, 8'h00);
    RST = 1'b0;
    host_read(8'h12, 8'h00);
    repeat (300) @(posedge CLK);
    #1;

    // Single write
    bus_start();
    check("busy_after_start", {7'd0, bif.busy}, 8'h01);
    write_byte(8'h42, 1'b0);
    write_byte(8'h12, 1'b0);
    wr_q.push_back({8'h12, 8'h80});
    write_byte(8'h80, 1'b0);
    bus_stop();
    qtr();
    check("busy_after_stop", {7'd0, bif.busy}, 8'h00);
    host_read(8'h12, 8'h80);

    // Burst with pointer wrap
    bus_start();
    write_byte(8'h42, 1'b0);
    write_byte(8'hFE, 1'b0);
    wr_q.push_back({8'hFE, 8'h11});
    write_byte(8'h11, 1'b0);
    wr_q.push_back({8'hFF, 8'h22});
    write_byte(8'h22, 1'b0);
    wr_q.push_back({8'h00, 8'h33});
    write_byte(8'h33, 1'b0);
    bus_stop();
    host_read(8'hFE, 8'h11);
    host_read(8'hFF, 8'h22);
    host_read(8'h00, 8'h33);

    // Wrong ID
    oe0 = oe_cycles;
    bus_start();
    write_byte(8'h60, 1'b1);
    write_byte(8'h12, 1'b1);
    write_byte(8'h55, 1'b1);
    bus_stop();
    check("wrong_id_oe_cycles", 8'(oe_cycles - oe0), 8'h00);
    host_read(8'h12, 8'h80);

    // Abort after 5 data bits
    bus_start();
    write_byte(8'h42, 1'b0);
    write_byte(8'h40, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    bus_stop();
    qtr();
    check("abort_busy", {7'd0, bif.busy}, 8'h00);
    host_read(8'h40, 8'h00);
    bus_start();
    write_byte(8'h42, 1'b0);
    write_byte(8'h40, 1'b0);
    wr_q.push_back({8'h40, 8'hD0});
    write_byte(8'hD0, 1'b0);
    bus_stop();
    host_read(8'h40, 8'hD0);

    // Glitches on idle bus and inside bit times
    repeat (4) @(posedge CLK);
    #1 m_sda = 1'b0;
    @(posedge CLK);
    #1 m_sda = 1'b1;
    qtr();
    check("glitch_idle_busy", {7'd0, bif.busy}, 8'h00);
    glitch = 1'b1;
    bus_start();
    write_byte(8'h42, 1'b0);
    write_byte(8'h30, 1'b0);
    wr_q.push_back({8'h30, 8'hA5});
    write_byte(8'hA5, 1'b0);
    glitch = 1'b0;
    bus_stop();
    host_read(8'h30, 8'hA5);

    // Reset while the ID ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h42 >> i));
    m_sda = 1'b1;
    check("ack_before_rst", {7'd0, bif.sda_oe}, 8'h01);
    RST = 1'b1;
    #1;
    check("rst_release_now", {7'd0, bif.sda_oe}, 8'h00);
    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_mid_busy", {7'd0, bif.busy}, 8'h00);
    qtr();
    m_scl = 1'b1; qtr(); qtr();
    m_scl = 1'b0; qtr();
    write_byte(8'h30, 1'b1);
    bus_stop();
    repeat (300) @(posedge CLK);
    host_read(8'h30, 8'h00);

    // Register read through repeated START
    bus_start();
    write_byte(8'h42, 1'b0);
    write_byte(8'h0A, 1'b0);
    wr_q.push_back({8'h0A, 8'h5B});
    write_byte(8'h5B, 1'b0);
    bus_stop();
    bus_start();
    write_byte(8'h42, 1'b0);
    write_byte(8'h0A, 1'b0);
    bus_start();
`ifdef SCCB_READ_EN
    write_byte(8'h43, 1'b0);
    read_byte(8'h5B, 1'b0);
    read_byte(8'h00, 1'b1);
    write_byte(8'hFF, 1'b1);
`else
    write_byte(8'h43, 1'b1);
`endif
    bus_stop();
    qtr();
    check("final_busy", {7'd0, bif.busy}, 8'h00);
    check("wr_q_left", 8'(wr_q.size()), 8'h00);
    check("bit_q_left", 8'(bit_q.size()), 8'h00);
    check("rd_q_left", 8'(rd_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
